// File: rtl/register_file_8bit.sv
// Register file: B C D E H L F A byte registers with byte, pair and masked-flag write ports.
// Latency: one cycle from write enable to stored value; reads are combinational.
// Backpressure: none; every enabled write is accepted at the next rising edge.
//
// Ports:
//   i_Clk, i_Reset              clock, asynchronous active-high reset
//   i_RdSelA/B -> o_RdDataA/B   byte reads (0=B 1=C 2=D 3=E 4=H 5=L 6=F 7=A)
//   i_PairRdSel -> o_PairRdData pair read (0=BC 1=DE 2=HL 3=AF), high byte first-named
//   i_WrEn/i_WrSel/i_WrData     byte write
//   i_PairWrEn/Sel/Data         16-bit pair write
//   i_FlagWrEn/Mask/Data        masked update of F[7:4] (Z N H C)
//   o_F                         current Z N H C
// Build option: define REGFILE_BYPASS_EN to forward the pending write to every read port.
module register_file_8bit #(
  parameter logic [7:0] A_RESET = 8'h01,
  parameter logic [7:0] F_RESET = 8'hB0
) (
  input  logic        i_Clk,
  input  logic        i_Reset,
  input  logic [2:0]  i_RdSelA,
  input  logic [2:0]  i_RdSelB,
  output logic [7:0]  o_RdDataA,
  output logic [7:0]  o_RdDataB,
  input  logic        i_WrEn,
  input  logic [2:0]  i_WrSel,
  input  logic [7:0]  i_WrData,
  input  logic        i_PairWrEn,
  input  logic [1:0]  i_PairWrSel,
  input  logic [15:0] i_PairWrData,
  input  logic [1:0]  i_PairRdSel,
  output logic [15:0] o_PairRdData,
  input  logic        i_FlagWrEn,
  input  logic [3:0]  i_FlagMask,
  input  logic [3:0]  i_FlagData,
  output logic [3:0]  o_F
);

  localparam logic [2:0] IDX_F = 3'd6;

  // Storage is indexed by the read/write select code, so F lives at 6 and A at 7.
  logic [7:0] rf   [8];
  logic [7:0] nxt  [8];
  logic [7:0] view [8];

  // AF is the odd pair: A (7) is the high byte and F (6) the low byte.
  function automatic logic [2:0] pair_hi(input logic [1:0] p);
    return (p == 2'd3) ? 3'd7 : {p, 1'b0};
  endfunction

  function automatic logic [2:0] pair_lo(input logic [1:0] p);
    return (p == 2'd3) ? 3'd6 : {p, 1'b1};
  endfunction

  // Pending state. Apply order encodes priority: pair write, then the byte
  // write overrides its register, then masked flag bits override F[7:4].
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      nxt[i] = rf[i];
    end
    if (!i_Reset) begin
      if (i_PairWrEn) begin
        nxt[pair_hi(i_PairWrSel)] = i_PairWrData[15:8];
        nxt[pair_lo(i_PairWrSel)] = i_PairWrData[7:0];
      end
      if (i_WrEn) begin
        nxt[i_WrSel] = i_WrData;
      end
      if (i_FlagWrEn) begin
        nxt[IDX_F][7:4] = (nxt[IDX_F][7:4] & ~i_FlagMask) | (i_FlagData & i_FlagMask);
      end
    end
    // Low nibble of F does not exist; keep it zero in storage and on reads.
    nxt[IDX_F][3:0] = 4'h0;
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      rf[0] <= 8'h00;
      rf[1] <= 8'h13;
      rf[2] <= 8'h00;
      rf[3] <= 8'hD8;
      rf[4] <= 8'h01;
      rf[5] <= 8'h4D;
      rf[6] <= {F_RESET[7:4], 4'h0};
      rf[7] <= A_RESET;
    end else begin
      for (int i = 0; i < 8; i++) begin
        rf[i] <= nxt[i];
      end
    end
  end

  // During reset nxt equals the stored reset values, so forwarding stays
  // consistent with writes being ignored.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
`ifdef REGFILE_BYPASS_EN
      view[i] = nxt[i];
`else
      view[i] = rf[i];
`endif
    end
  end

  assign o_RdDataA    = view[i_RdSelA];
  assign o_RdDataB    = view[i_RdSelB];
  assign o_PairRdData = {view[pair_hi(i_PairRdSel)], view[pair_lo(i_PairRdSel)]};
  assign o_F          = view[IDX_F][7:4];

endmodule

// File: tb/tb_register_file_8bit.sv
// Bench for register_file_8bit: directed vectors against a register-level model.
// Latency: model applies writes at each rising edge; outputs compared on falling edges.
// Backpressure: not applicable.
module tb_register_file_8bit;

  logic        i_Clk = 1'b0;
  logic        i_Reset;
  logic [2:0]  i_RdSelA, i_RdSelB, i_WrSel;
  logic [7:0]  o_RdDataA, o_RdDataB, i_WrData;
  logic        i_WrEn, i_PairWrEn, i_FlagWrEn;
  logic [1:0]  i_PairWrSel, i_PairRdSel;
  logic [15:0] i_PairWrData, o_PairRdData;
  logic [3:0]  i_FlagMask, i_FlagData, o_F;

  register_file_8bit dut (
    .i_Clk(i_Clk), .i_Reset(i_Reset),
    .i_RdSelA(i_RdSelA), .i_RdSelB(i_RdSelB),
    .o_RdDataA(o_RdDataA), .o_RdDataB(o_RdDataB),
    .i_WrEn(i_WrEn), .i_WrSel(i_WrSel), .i_WrData(i_WrData),
    .i_PairWrEn(i_PairWrEn), .i_PairWrSel(i_PairWrSel), .i_PairWrData(i_PairWrData),
    .i_PairRdSel(i_PairRdSel), .o_PairRdData(o_PairRdData),
    .i_FlagWrEn(i_FlagWrEn), .i_FlagMask(i_FlagMask), .i_FlagData(i_FlagData),
    .o_F(o_F)
  );

  always #5 i_Clk = ~i_Clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Model: register contents by select code, plus the value the next edge will commit.
  logic [7:0] mdl [8];
  logic [7:0] nx  [8];
  int pair_h [4] = '{0, 2, 4, 7};
  int pair_l [4] = '{1, 3, 5, 6};

  function automatic void model_reset();
    mdl = '{8'h00, 8'h13, 8'h00, 8'hD8, 8'h01, 8'h4D, 8'hB0, 8'h01};
  endfunction

  function automatic void calc_next();
    logic [7:0] fv;
    nx = mdl;
    if (i_Reset === 1'b0) begin
      if (i_PairWrEn) begin
        nx[pair_h[i_PairWrSel]] = i_PairWrData[15:8];
        nx[pair_l[i_PairWrSel]] = i_PairWrData[7:0];
      end
      if (i_WrEn) nx[i_WrSel] = i_WrData;
      if (i_FlagWrEn) begin
        fv = nx[6];
        for (int b = 0; b < 4; b++)
          if (i_FlagMask[b]) fv[4+b] = i_FlagData[b];
        nx[6] = fv;
      end
    end
    nx[6] = nx[6] & 8'hF0;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare of every output against the model.
  always @(negedge i_Clk) begin
    if (chk_en) begin
      logic [7:0] ev [8];
      calc_next();
`ifdef REGFILE_BYPASS_EN
      ev = nx;
`else
      ev = mdl;
`endif
      chk("rd_a", {8'h00, o_RdDataA}, {8'h00, ev[i_RdSelA]});
      chk("rd_b", {8'h00, o_RdDataB}, {8'h00, ev[i_RdSelB]});
      chk("pair_rd", o_PairRdData, {ev[pair_h[i_PairRdSel]], ev[pair_l[i_PairRdSel]]});
      chk("o_f", {12'h000, o_F}, {12'h000, ev[6][7:4]});
    end
  end

  task automatic idle();
    i_WrEn = 1'b0; i_PairWrEn = 1'b0; i_FlagWrEn = 1'b0;
  endtask

  // Commit one edge into the model, then move inputs off the edge.
  task automatic tick();
    @(posedge i_Clk);
    calc_next();
    if (i_Reset === 1'b0) mdl = nx;
    #1;
  endtask

  initial begin
    i_Reset = 1'b1;
    i_RdSelA = 3'd7; i_RdSelB = 3'd0; i_WrSel = 3'd0; i_WrData = 8'h00;
    i_PairWrSel = 2'd0; i_PairWrData = 16'h0000; i_PairRdSel = 2'd2;
    i_FlagMask = 4'h0; i_FlagData = 4'h0;
    idle();
    model_reset();
    #6 chk_en = 1'b1;
    #6 i_Reset = 1'b0;
    #1;
    chk("reset_a", {8'h00, o_RdDataA}, 16'h0001);
    chk("reset_f", {12'h000, o_F}, 16'h000B);
    chk("reset_hl", o_PairRdData, 16'h014D);

    // Read sweep over every select with all enables low.
    for (int i = 0; i < 8; i++) begin
      i_RdSelA = 3'(i); i_RdSelB = 3'(7 - i); i_PairRdSel = 2'(i);
      i_WrSel = 3'(i); i_PairWrSel = 2'(i);
      tick();
    end

    // Byte write H = FF.
    i_RdSelA = 3'd4; i_WrEn = 1'b1; i_WrSel = 3'd4; i_WrData = 8'hFF;
    tick(); idle(); #1;
    chk("byte_h", {8'h00, o_RdDataA}, 16'h00FF);

    // Pair write AF = 12FF: low nibble of F dropped.
    i_RdSelA = 3'd7; i_RdSelB = 3'd6; i_PairRdSel = 2'd3;
    i_PairWrEn = 1'b1; i_PairWrSel = 2'd3; i_PairWrData = 16'h12FF;
    tick(); idle(); #1;
    chk("pair_af_a", {8'h00, o_RdDataA}, 16'h0012);
    chk("pair_af_f", {8'h00, o_RdDataB}, 16'h00F0);
    chk("pair_af_of", {12'h000, o_F}, 16'h000F);
    chk("pair_af_rd", o_PairRdData, 16'h12F0);

    // Pair BC and byte C in one cycle.
    i_RdSelA = 3'd0; i_RdSelB = 3'd1;
    i_PairWrEn = 1'b1; i_PairWrSel = 2'd0; i_PairWrData = 16'hAAAA;
    i_WrEn = 1'b1; i_WrSel = 3'd1; i_WrData = 8'h55;
    tick(); idle(); #1;
    chk("prio_b", {8'h00, o_RdDataA}, 16'h00AA);
    chk("prio_c", {8'h00, o_RdDataB}, 16'h0055);

    // F = B0, then flags Z N H with byte write F = F0 supplying C.
    i_RdSelA = 3'd6; i_WrEn = 1'b1; i_WrSel = 3'd6; i_WrData = 8'hB0;
    tick();
    i_WrData = 8'hF0; i_FlagWrEn = 1'b1; i_FlagMask = 4'b1110; i_FlagData = 4'b0101;
    tick(); idle(); #1;
    chk("flag_byte_f", {8'h00, o_RdDataA}, 16'h0050);
    chk("flag_byte_of", {12'h000, o_F}, 16'h0005);

    // Random mix of all write ports, checked by the per-cycle compare.
    for (int i = 0; i < 60; i++) begin
      i_RdSelA = 3'($urandom); i_RdSelB = 3'($urandom); i_PairRdSel = 2'($urandom);
      i_WrEn = 1'($urandom); i_WrSel = 3'($urandom); i_WrData = 8'($urandom);
      i_PairWrEn = 1'($urandom); i_PairWrSel = 2'($urandom); i_PairWrData = 16'($urandom);
      i_FlagWrEn = 1'($urandom); i_FlagMask = 4'($urandom); i_FlagData = 4'($urandom);
      tick();
    end

    // Asynchronous reset mid-cycle with writes held active.
    idle();
    i_RdSelA = 3'd7; i_PairRdSel = 2'd2;
    @(negedge i_Clk); #2;
    i_Reset = 1'b1; model_reset(); #1;
    chk("async_a", {8'h00, o_RdDataA}, 16'h0001);
    chk("async_f", {12'h000, o_F}, 16'h000B);
    chk("async_hl", o_PairRdData, 16'h014D);
    i_WrEn = 1'b1; i_WrSel = 3'd7; i_WrData = 8'h99;
    i_FlagWrEn = 1'b1; i_FlagMask = 4'hF; i_FlagData = 4'h0;
    tick(); tick();
    chk("rst_hold_a", {8'h00, o_RdDataA}, 16'h0001);
    chk("rst_hold_f", {12'h000, o_F}, 16'h000B);
    #2 i_Reset = 1'b0;
    tick(); idle(); #1;
    chk("post_rst_a", {8'h00, o_RdDataA}, 16'h0099);
    chk("post_rst_f", {12'h000, o_F}, 16'h0000);
    tick();

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
